// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host byte receiver with sync, glitch filter, parity/stop check and timeout.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t r_state, w_next;
  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic r_filt, r_filt_d, r_fall, r_bit, r_par, r_valid, r_err;
  logic [7:0] r_fcnt, r_shift, r_data;
  logic [2:0] r_bcnt;
  logic [TW-1:0] r_tcnt;
  logic w_tout, w_ok, w_bad;
  assign rx_data  = r_data;
  assign rx_valid = r_valid;
  assign rx_err   = r_err;
  assign busy     = r_state != IDLE;
  assign w_tout   = r_state != IDLE && r_tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    w_next = r_state;
    w_ok   = 1'b0;
    w_bad  = 1'b0;
    if (r_fall) begin
      case (r_state)
        IDLE:    w_next = r_bit ? IDLE : DATA;
        DATA:    w_next = r_bcnt == 3'd7 ? PARITY : DATA;
        PARITY:  w_next = STOP;
        default: begin
          w_next = IDLE;
          w_ok   = r_bit & ^{r_shift, r_par};
          w_bad  = ~w_ok;
        end
      endcase
    end else if (w_tout) begin
      w_next = IDLE;
      w_bad  = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fall   <= 1'b0;
      r_bit    <= 1'b1;
      r_fcnt   <= '0;
      r_tcnt   <= '0;
      r_bcnt   <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      // a disagreeing sample run must last FILTER_LEN cycles before the filtered clock follows
      r_fcnt   <= (r_clk_s2 == r_filt || r_fcnt == 8'(FILTER_LEN - 1)) ? 8'd0 : r_fcnt + 8'd1;
      r_filt   <= (r_clk_s2 != r_filt && r_fcnt == 8'(FILTER_LEN - 1)) ? r_clk_s2 : r_filt;
      r_filt_d <= r_filt;
      r_fall   <= r_filt_d & ~r_filt;
      r_bit    <= r_dat_s2;
      r_tcnt   <= (r_fall || r_state == IDLE || w_tout) ? '0 : r_tcnt + 1'b1;
      r_valid  <= w_ok;
      r_err    <= w_bad;
      if (w_ok) r_data <= r_shift;
      if (r_fall && r_state == IDLE) r_bcnt <= 3'd0;
      if (r_fall && r_state == DATA) begin
        r_shift <= {r_bit, r_shift[7:1]};
        r_bcnt  <= r_bcnt + 3'd1;
      end
      if (r_fall && r_state == PARITY) r_par <= r_bit;
    end
  end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: PS/2 device model driving ps2_rx, scoreboard of expected bytes/errors.
`timescale 1ns/1ps
module tb_ps2_rx;
  localparam int FL = 8;
  localparam int TO = 2000;
  localparam int TOUT_LAT = TO + FL + 4;
  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, rx_err, busy;
  typedef struct {logic err; logic [7:0] data;} exp_t;
  exp_t sb[$];
  logic [7:0] m_data = 8'h00;
  int n_chk = 0, n_fail = 0, cyc = 0, last_fall = 0;
  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (rx_valid || rx_err)) begin
      chk("excl", {31'd0, rx_valid & rx_err}, 0);
      if (sb.size() == 0) chk("unexpected", {22'd0, rx_err, rx_valid, rx_data}, 0);
      else begin
        e = sb.pop_front();
        chk("kind", {31'd0, rx_err}, {31'd0, e.err});
        chk("data", {24'd0, rx_data}, {24'd0, e.data});
      end
    end
  end
  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic ps2_bit(input logic v, input logic g);
    ps2_data = v;
    wt(20);
    ps2_clk = 1'b0;
    last_fall = cyc;
    wt(40);
    ps2_clk = 1'b1;
    if (g) begin
      wt(7); ps2_clk = 1'b0; wt(5); ps2_clk = 1'b1; wt(8);
    end else wt(20);
  endtask
  task automatic send(input logic [7:0] b, input logic par_flip, input logic stop, input logic g);
    logic par;
    logic ok;
    par = ~^b ^ par_flip;
    ok = !par_flip && stop;
    sb.push_back('{err: !ok, data: ok ? b : m_data});
    if (ok) m_data = b;
    ps2_bit(1'b0, g);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], g);
    ps2_bit(par, g);
    ps2_bit(stop, g);
    ps2_data = 1'b1;
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk(tag, sb.size(), 0);
  endtask
  initial begin
    logic seen;
    int lat;
    wt(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", {24'd0, rx_data}, 0);
    chk("rst_valid", {31'd0, rx_valid}, 0);
    chk("rst_err", {31'd0, rx_err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    send(8'hA5, 1'b0, 1'b1, 1'b0);
    drain("drain_a5");
    chk("a5_data", {24'd0, rx_data}, 32'hA5);
    chk("a5_busy", {31'd0, busy}, 0);
    send(8'hFA, 1'b0, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b1, 1'b0);
    send(8'h01, 1'b0, 1'b1, 1'b0);
    drain("drain_b2b");
    send(8'h01, 1'b1, 1'b1, 1'b0);
    drain("drain_par");
    chk("par_keep", {24'd0, rx_data}, 32'h01);
    send(8'h01, 1'b0, 1'b0, 1'b0);
    drain("drain_stop");
    chk("stop_keep", {24'd0, rx_data}, 32'h01);
    send(8'h3C, 1'b0, 1'b1, 1'b1);
    drain("drain_glitch");
    chk("glitch_data", {24'd0, rx_data}, 32'h3C);
    seen = 1'b0;
    ps2_clk = 1'b0;
    wt(9);
    ps2_clk = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | busy;
    end
    chk("idle_pulse_busy", {31'd0, seen}, 0);
    sb.push_back('{err: 1'b1, data: m_data});
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0], 1'b0);
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rx_err) begin
        lat = cyc - last_fall;
        break;
      end
    end
    chk("tout_lat", (lat >= TOUT_LAT - 2 && lat <= TOUT_LAT + 2) ? TOUT_LAT : lat, TOUT_LAT);
    @(negedge clk);
    chk("tout_busy", {31'd0, busy}, 0);
    drain("drain_tout");
    send(8'h55, 1'b0, 1'b1, 1'b0);
    drain("drain_55");
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_data = 8'h00;
    chk("mid_rst_out", {21'd0, rx_data, rx_valid, rx_err, busy}, 0);
    ps2_data = 1'b1;
    wt(100);
    chk("mid_rst_quiet", {30'd0, rx_valid, rx_err}, 0);
    send(8'hC3, 1'b0, 1'b1, 1'b0);
    drain("drain_c3");
    chk("c3_data", {24'd0, rx_data}, 32'hC3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- Receive-only PS/2 device-to-host byte deserialiser.
- Sits directly upstream of the mouse decode logic inside top_vga. It takes the raw ps2_clk/ps2_data board pins and delivers validated 8-bit bytes, one-cycle strobed, in the 100 MHz domain.
- Handles metastability, glitch filtering, odd-parity check, stop-bit check and inter-edge timeout.
- Never drives the PS/2 lines; host-to-device transmit is a separate block.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered ps2_clk changes value (range 2..255).
- TIMEOUT_CYCLES, 20000: max clk cycles allowed between filtered ps2_clk falling edges inside a frame (200 us at 100 MHz).

Ports:
- clk, input, 1: system clock (clk_100 domain).
- rst, input, 1: synchronous, active-high reset.
- ps2_clk, input, 1: raw PS/2 clock pin, asynchronous.
- ps2_data, input, 1: raw PS/2 data pin, asynchronous.
- rx_data, output, 8: last correctly received byte; changes only together with rx_valid.
- rx_valid, output, 1: one-cycle pulse, rx_data is new.
- rx_err, output, 1: one-cycle pulse on parity, stop-bit or timeout error.
- busy, output, 1: high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst sampled high on a clk edge):
  - rx_data=8'h00, rx_valid=0, rx_err=0, busy=0, state=IDLE.
  - Both synchroniser stages=1; filtered clock=1; filter and timeout counters=0.
  - Applies even mid-frame: the partial frame is discarded and no rx_err is raised.
- Synchroniser: 2 flip-flops per input line.
- Filter:
  - Counter runs while the synchronised ps2_clk differs from the filtered value.
  - When the counter reaches FILTER_LEN-1, the filtered value takes the synchronised value and the counter clears.
  - Any agreeing sample clears the counter, so glitches shorter than FILTER_LEN cycles are ignored.
- Edge detect: a fall is filtered value 1 in the previous cycle and 0 now. Synchronised ps2_data is sampled in the same cycle.
- FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on fall with data=0 (start bit), go to DATA with bit count 0. On fall with data=1, stay in IDLE with no error.
  - DATA: on each fall, shift the data bit in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on fall, store the bit and go to STOP.
  - STOP: on fall, return to IDLE. If stop bit=1 AND (XOR of 8 data bits ^ parity)=1, load rx_data and pulse rx_valid in the next cycle. Otherwise pulse rx_err in the next cycle and leave rx_data unchanged.
- Timeout:
  - Counter clears on every fall and in IDLE, and increments in other states.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, pulse rx_err once, clear the counter.
  - A fall in the same cycle as the timeout wins: it is processed as a normal edge.
- rx_valid and rx_err are never high in the same cycle; each is high for exactly one cycle per frame.
- Latency: the rx_valid/rx_err pulse occurs a constant FILTER_LEN+4 cycles (±1, fixed per implementation) after the first clk edge that samples raw ps2_clk low for the stop bit.
- busy rises in the cycle after the start-bit fall is detected. It falls in the cycle the FSM returns to IDLE.
- Back-to-back frames with no idle gap are accepted. A fall on the cycle after STOP→IDLE is treated as the next start bit.

Test Plan:
1. Bench device model, ps2_clk half-period 40 cycles, FILTER_LEN=8, TIMEOUT_CYCLES=2000. Frame 0xA5 (bits start0, 1,0,1,0,0,1,0,1, parity1, stop1) -> single rx_valid pulse, rx_data=8'hA5, rx_err never high, busy low after the pulse.
2. Frames 0xFA (parity 1), 0x00 (parity 1), 0x01 (parity 0) back-to-back, no idle gap -> three rx_valid pulses in order with rx_data 8'hFA, 8'h00, 8'h01.
3. Frame 0x01 sent with parity bit 1 (wrong) -> one rx_err pulse, no rx_valid, rx_data keeps previous value 8'h01 from scenario 2. Repeat with stop bit 0 -> same response.
4. Glitch injection: 5-cycle low pulses on ps2_clk mid-bit during a 0x3C frame -> rx_data=8'h3C, no rx_err. A 9-cycle pulse in IDLE with data=1 -> ignored, no outputs.
5. Stop toggling ps2_clk after 4 data bits -> rx_err pulse exactly TIMEOUT_CYCLES(2000) ±1 cycle after the last detected fall, busy=0. A following 0x55 frame is received correctly.
6. Assert rst for 1 cycle mid-frame after 3 data bits -> all outputs 0 on the next cycle, no rx_err. A fresh 0xC3 frame then yields rx_valid with rx_data=8'hC3.
